// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
//
// Pops words from a push/pop FIFO (registered-read data port) and sends each
// one as an asynchronous serial frame on tx: start bit (0), WORDLENGHT data
// bits LSB first, optional even-parity bit, stop bit (1). Every frame bit is
// held for CLKS_PER_BIT clock cycles.
//
// Optional feature macro: FIFO_UART_TX_PARITY_EN
//   defined   -> a parity bit (XOR of the word) is sent between data and stop
//   undefined -> stop bit follows the last data bit directly
//
// Parameters:
//   WORDLENGHT   : data bits per frame (must match FIFO word width)
//   CLKS_PER_BIT : clock cycles per frame bit (>= 2)
//
// Ports:
//   clk        : clock, all logic on rising edge
//   reset      : synchronous active-high reset
//   enable     : allows new frames to start; never aborts a frame in progress
//   fifo_empty : FIFO empty flag
//   fifo_data  : FIFO head word (registered RAM read)
//   fifo_pop   : one-cycle pop strobe to the FIFO, one per word
//   tx         : serial output, idles high
//   busy       : high from WAIT through the last stop-bit cycle
//   word_done  : one-cycle pulse on the last stop-bit cycle
// -----------------------------------------------------------------------------
module fifo_uart_tx #(
    parameter int WORDLENGHT   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [WORDLENGHT-1:0] fifo_data,
    output logic                  fifo_pop,
    output logic                  tx,
    output logic                  busy,
    output logic                  word_done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(WORDLENGHT + 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORDLENGHT - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        LOAD,
        START,
        DATA,
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t                state_reg, state_next;
    logic [BAUD_W-1:0]     baud_reg, baud_next;
    logic [BIT_W-1:0]      bit_reg, bit_next;
    logic [WORDLENGHT-1:0] shift_reg, shift_next;
    logic                  tx_reg, tx_next;
    logic                  pop_reg, pop_next;
    logic                  busy_reg, busy_next;
    logic                  done_reg, done_next;
    logic                  bit_end;
`ifdef FIFO_UART_TX_PARITY_EN
    logic                  parity_reg, parity_next;
`endif

    // Last cycle of the current frame bit.
    assign bit_end = (baud_reg == BAUD_LAST);

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            baud_reg   <= '0;
            bit_reg    <= '0;
            shift_reg  <= '0;
            tx_reg     <= 1'b1;
            pop_reg    <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_reg <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            baud_reg   <= baud_next;
            bit_reg    <= bit_next;
            shift_reg  <= shift_next;
            tx_reg     <= tx_next;
            pop_reg    <= pop_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_reg <= parity_next;
`endif
        end
    end

    // Next state, counters and shift register.
    always_comb begin
        state_next  = state_reg;
        baud_next   = baud_reg;
        bit_next    = bit_reg;
        shift_next  = shift_reg;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_next = parity_reg;
`endif
        case (state_reg)
            IDLE: begin
                baud_next = '0;
                bit_next  = '0;
                if (enable && !fifo_empty) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                // Head word has had one cycle to appear on fifo_data.
                baud_next  = '0;
                state_next = fifo_empty ? IDLE : LOAD;
            end
            LOAD: begin
                shift_next  = fifo_data;
`ifdef FIFO_UART_TX_PARITY_EN
                parity_next = ^fifo_data;
`endif
                baud_next   = '0;
                bit_next    = '0;
                state_next  = START;
            end
            START: begin
                baud_next = bit_end ? '0 : baud_reg + 1'b1;
                if (bit_end) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                baud_next = bit_end ? '0 : baud_reg + 1'b1;
                if (bit_end) begin
                    shift_next = shift_reg >> 1;
                    if (bit_reg == BIT_LAST) begin
                        bit_next = '0;
`ifdef FIFO_UART_TX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end else begin
                        bit_next = bit_reg + 1'b1;
                    end
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: begin
                baud_next = bit_end ? '0 : baud_reg + 1'b1;
                if (bit_end) begin
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                baud_next = bit_end ? '0 : baud_reg + 1'b1;
                if (bit_end) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs are registered, so their next values are decoded from the
    // state/datapath the block is about to enter.
    always_comb begin
        tx_next   = 1'b1;
        pop_next  = 1'b0;
        done_next = 1'b0;
        busy_next = (state_next != IDLE);
        case (state_next)
            LOAD:   pop_next = 1'b1;
            START:  tx_next  = 1'b0;
            DATA:   tx_next  = shift_next[0];
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: tx_next  = parity_next;
`endif
            STOP:   done_next = (baud_next == BAUD_LAST);
            default: begin
                tx_next = 1'b1;
            end
        endcase
    end

    assign tx        = tx_reg;
    assign fifo_pop  = pop_reg;
    assign busy      = busy_reg;
    assign word_done = done_reg;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_fifo_uart_tx
//
// Bench for fifo_uart_tx (WORDLENGHT=8, CLKS_PER_BIT=4). A behavioural FIFO
// feeds the DUT; every word handed to the FIFO that is expected to go out is
// queued (with its expected start-bit cycle where that is fixed) in a
// scoreboard. An independent monitor decodes frames on tx and checks each one
// against the scoreboard, cycle by cycle.
// -----------------------------------------------------------------------------
module tb_fifo_uart_tx;

    localparam int WL = 8;
    localparam int C  = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FLEN = WL + 2 + PAR;   // frame bits

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          fifo_empty = 1'b1;
    logic [WL-1:0] fifo_data  = '0;
    logic          fifo_pop;
    logic          tx;
    logic          busy;
    logic          word_done;

    fifo_uart_tx #(.WORDLENGHT(WL), .CLKS_PER_BIT(C)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_pop   (fifo_pop),
        .tx         (tx),
        .busy       (busy),
        .word_done  (word_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors   = 0;
    int n_checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, expv);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        errors++;
        $display("FAIL %s @cycle %0d", name, cyc);
    endtask

    // ---------------- behavioural FIFO (registered head read) ----------------
    logic [WL-1:0] pend_q[$];
    logic [WL-1:0] fifo_q[$];

    always @(posedge clk) begin
        if (fifo_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
        while (pend_q.size() > 0) fifo_q.push_back(pend_q.pop_front());
        fifo_empty <= (fifo_q.size() == 0);
        fifo_data  <= (fifo_q.size() > 0) ? fifo_q[0] : '0;
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [WL-1:0] word;
        int            start;   // expected start-bit cycle, -1 = not fixed
    } exp_t;
    exp_t exp_q[$];

    task automatic fifo_push(input logic [WL-1:0] w);
        pend_q.push_back(w);
    endtask

    task automatic exp_push(input logic [WL-1:0] w, input int start);
        exp_t e;
        e.word  = w;
        e.start = start;
        exp_q.push_back(e);
    endtask

    // ---------------- monitor ----------------
    bit              mon_active  = 0;
    bit              mon_valid   = 0;
    bit              post_frame  = 0;
    bit              pop_pending = 0;
    int              pop_cyc     = 0;
    int              n_pops      = 0;
    int              n_frames    = 0;
    int              mon_k       = 0;
    int              frame_start = 0;
    int              frame_errs  = 0;
    logic [WL-1:0]   mon_word;
    logic [FLEN-1:0] frame;

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            mon_active  = 0;
            pop_pending = 0;
            post_frame  = 0;
        end else begin
            if (!mon_active && tx === 1'b0) begin
                chk("pop_one_cycle_before_start", pop_pending && (pop_cyc == cyc - 1), 1);
                pop_pending = 0;
                frame_start = cyc;
                frame_errs  = errors;
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_frame");
                    mon_valid = 0;
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    mon_word  = e.word;
                    mon_valid = 1;
                    frame[0]  = 1'b0;
                    for (int i = 0; i < WL; i++) frame[1+i] = e.word[i];
                    if (PAR != 0) frame[WL+1] = ^e.word;
                    frame[FLEN-1] = 1'b1;
                    if (e.start >= 0) chk("start_cycle", cyc, e.start);
                end
                mon_active = 1;
                mon_k      = 0;
            end
            if (mon_active) begin
                if (mon_valid) chk("tx_bit", tx, frame[mon_k / C]);
                chk("busy_in_frame", busy, 1);
                chk("word_done", word_done, (mon_k == FLEN * C - 1));
                chk("no_pop_in_frame", fifo_pop, 0);
                mon_k++;
                if (mon_k == FLEN * C) begin
                    mon_active = 0;
                    post_frame = 1;
                    n_frames++;
                    $display("frame %0d: word=%02h start=%0d %s", n_frames, mon_word,
                             frame_start, (errors == frame_errs) ? "ok" : "bad");
                end
            end else begin
                chk("word_done_idle", word_done, 0);
                if (post_frame) chk("busy_after_stop", busy, 0);
                post_frame = 0;
                if (fifo_pop === 1'b1) begin
                    chk("pop_not_repeated", pop_pending, 0);
                    chk("busy_at_pop", busy, 1);
                    pop_pending = 1;
                    pop_cyc     = cyc;
                    n_pops++;
                end else if (pop_pending && cyc > pop_cyc) begin
                    fail_now("start_after_pop");
                    pop_pending = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input int max_cycles, input bit need_fifo_empty);
        int n = 0;
        while ((exp_q.size() != 0 || mon_active || busy !== 1'b0 ||
                (need_fifo_empty && (fifo_q.size() != 0 || pend_q.size() != 0)))
               && n < max_cycles) begin
            step();
            n++;
        end
        n_checks++;
        if (n >= max_cycles) begin
            errors++;
            $display("FAIL wait_idle timeout after %0d cycles, %0d words outstanding",
                     n, exp_q.size());
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p, q, pops0;
        logic [WL-1:0] w;

        // Reset held with FIFO non-empty and enable high.
        reset  = 1'b1;
        enable = 1'b1;
        fifo_push(8'h3C);
        exp_push(8'h3C, -1);
        repeat (3) begin
            @(negedge clk);
            chk("reset_tx", tx, 1);
            chk("reset_pop", fifo_pop, 0);
            chk("reset_busy", busy, 0);
            chk("reset_word_done", word_done, 0);
        end
        step();
        reset = 1'b0;
        wait_idle(200, 1);

        // Single word 0xA5: FIFO non-empty from p+1, start bit from p+4.
        step();
        p = cyc;
        fifo_push(8'hA5);
        exp_push(8'hA5, p + 4);
        wait_idle(200, 1);

        // Back-to-back words: next start follows the stop bit by 4 cycles.
        step();
        p = cyc;
        fifo_push(8'h01);
        fifo_push(8'h80);
        exp_push(8'h01, p + 4);
        exp_push(8'h80, p + 4 + FLEN * C + 3);
        wait_idle(300, 1);

        // enable low: word stays in the FIFO, line idles.
        step();
        enable = 1'b0;
        pops0  = n_pops;
        fifo_push(8'h5A);
        repeat (50) begin
            @(negedge clk);
            chk("disabled_tx_idle", tx, 1);
            chk("disabled_no_pop", fifo_pop, 0);
        end
        step();
        q = cyc;
        enable = 1'b1;
        exp_push(8'h5A, q + 3);
        wait_idle(200, 1);

        // enable dropped at cycle 10 of a frame: frame completes, no next pop.
        step();
        p = cyc;
        pops0 = n_pops;
        fifo_push(8'hC3);
        fifo_push(8'h3C);
        exp_push(8'hC3, p + 4);
        while (cyc < p + 11) step();
        enable = 1'b0;
        wait_idle(200, 0);
        repeat (40) step();
        chk("pops_after_disable", n_pops - pops0, 1);
        chk("fifo_left_after_disable", fifo_q.size(), 1);
        step();
        q = cyc;
        enable = 1'b1;
        exp_push(8'h3C, q + 3);
        wait_idle(200, 1);

        // reset at cycle 20 of a frame: popped word is lost.
        step();
        p = cyc;
        pops0 = n_pops;
        fifo_push(8'h96);
        exp_push(8'h96, p + 4);
        while (cyc < p + 21) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("midreset_tx", tx, 1);
        chk("midreset_busy", busy, 0);
        chk("midreset_pop", fifo_pop, 0);
        chk("midreset_word_done", word_done, 0);
        repeat (10) step();
        chk("midreset_pop_count", n_pops - pops0, 1);
        step();
        p = cyc;
        fifo_push(8'h4B);
        exp_push(8'h4B, p + 4);
        wait_idle(200, 1);

        // Randomized words, gaps and enable-low periods.
        for (int k = 0; k < 30; k++) begin
            if ($urandom_range(3) == 0) begin
                enable = 1'b0;
                repeat ($urandom_range(80)) step();
                enable = 1'b1;
            end
            w = WL'($urandom);
            fifo_push(w);
            exp_push(w, -1);
            repeat ($urandom_range(50)) step();
        end
        enable = 1'b1;
        wait_idle(4000, 1);

        $display("Result: errors=%0d of %0d checks", errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Downstream consumer of the team's push/pop FIFO. Pops one word at a time through the FIFO's `pop`/`empty_out`/`data_out` interface and serializes it as an asynchronous frame on `tx`: start bit, data bits LSB first, optional parity bit, stop bit. Each bit is held for a fixed number of clock cycles. Sits between the FIFO and the board serial pin.

## Interface
- `WORDLENGHT`, 8: data bits per frame; must match the FIFO word width.
- `CLKS_PER_BIT`, 16: clock cycles each frame bit is held; ≥2.

Ports:
- `clk` input 1: single clock; all logic rises on this edge.
- `reset` input 1: synchronous, active-high.
- `enable` input 1: when high, new frames may start; never aborts a frame in progress.
- `fifo_empty` input 1: from FIFO `empty_out`.
- `fifo_data` input WORDLENGHT: from FIFO `data_out`, which is a registered RAM read of the head word.
- `fifo_pop` output 1: to FIFO `pop`; high for exactly one cycle per word.
- `tx` output 1: serial line; idles high.
- `busy` output 1: high from WAIT through the last stop-bit cycle.
- `word_done` output 1: one-cycle pulse on the last cycle of the stop bit.

## Operation
- Reset values: `tx`=1, `fifo_pop`=0, `busy`=0, `word_done`=0, state IDLE, all counters 0.
- FSM states: IDLE, WAIT, LOAD, START, DATA, [PARITY], STOP.
- IDLE: if `enable && !fifo_empty`, go to WAIT; otherwise stay.
- WAIT: allows one cycle for the FIFO's registered read of the head word to settle.
  - If `fifo_empty` is high here, return to IDLE with no pop.
  - Otherwise go to LOAD.
- LOAD: `fifo_pop`=1; capture `fifo_data` into the shift register in this same cycle; go to START.
- START: `tx`=0 for CLKS_PER_BIT cycles.
- DATA: `tx`=shift[0]; shift right every CLKS_PER_BIT cycles; runs WORDLENGHT bits.
- STOP: `tx`=1 for CLKS_PER_BIT cycles; `word_done`=1 on its last cycle; then IDLE.
- Counters:
  - Baud counter, width CeilLog2(CLKS_PER_BIT): counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
  - Bit counter, width CeilLog2(WORDLENGHT+1): counts 0..WORDLENGHT-1.
- `tx`, `fifo_pop`, `busy` and `word_done` are registered outputs.
- `enable` falling mid-frame: the frame completes; the block then stays in IDLE.
- `reset` mid-frame:
  - Next cycle all outputs are at reset values and the frame is abandoned.
  - A word already popped is lost; no extra pop is issued.
- FIFO goes non-empty during STOP: it is not seen until IDLE.

## Timing
- Cycle n: IDLE sees `enable && !fifo_empty`.
- n+1: WAIT. n+2: LOAD, `fifo_pop`=1. n+3: first start-bit cycle.
- Start bit: n+3 .. n+2+C, where C=CLKS_PER_BIT.
- Data bit i: n+3+C(1+i) .. n+2+C(2+i).
- Frame length on `tx`: (WORDLENGHT+2)·C cycles, or +C with parity.
- Back-to-back gap: `word_done` at cycle m, IDLE at m+1, WAIT at m+2, next pop at m+3.
  - `tx` is therefore high for 3 extra cycles between frames.

## Configuration
- `FIFO_UART_TX_PARITY_EN` defined:
  - PARITY state inserted between DATA and STOP.
  - `tx` = XOR of the captured word (even parity) for C cycles.
- Undefined: no PARITY state; STOP follows the last data bit directly.

## Test plan
(WORDLENGHT=8, CLKS_PER_BIT=4, cycle 0 = first cycle `fifo_empty`=0 with `enable`=1.)
- Reset held 3 cycles with FIFO non-empty -> `tx`=1, `fifo_pop`=0, `busy`=0, `word_done`=0 throughout.
- Word 0xA5, no parity -> expected response:
  - `fifo_pop` high at cycle 2 only.
  - `tx`=0 for cycles 3–6.
  - Data bits 1,0,1,0,0,1,0,1 over cycles 7–38, 4 cycles each.
  - Stop bit on cycles 39–42; `word_done` at 42.
- Same word with `FIFO_UART_TX_PARITY_EN` -> parity bit 0 on cycles 39–42, stop on 43–46, `word_done` at 46.
- Words 0x01 then 0x80 queued, no parity -> second `fifo_pop` at cycle 45; second start bit on cycles 46–49.
- `enable`=0 with FIFO non-empty -> no pop and `tx`=1 indefinitely; dropping `enable` at cycle 10 of a frame -> frame completes, no further pop.
- `reset` pulsed at cycle 20 mid-frame -> cycle 21 `tx`=1, `busy`=0, no pop; a new frame starts only after a fresh IDLE→WAIT sequence.
